mult_div_unit: RTL and testbench

//  Multi-cycle integer multiply/divide unit with architectural HI/LO registers.

---
 rtl/mult_div_unit.sv | 137 +++++++++++++
 tb/tb_mult_div_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle integer multiply/divide unit holding the architectural HI/LO
// registers for the MIPS datapath.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  launch an operation (sampled only while idle)
//   op     000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x no-op
//   srcA   rs operand, srcB rt operand
//   busy   high while a mul/div is in flight (CALC, SIGN, DONE)
//   done   one-cycle pulse; hi/lo already hold the new result
//   hi/lo  HI (upper product / remainder) and LO (lower product / quotient)
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StSign, StDone} stateT;

  stateT            stateQ, stateD;
  logic [CntW-1:0]  cntQ;
  // Multiply: {upper partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, remaining dividend bits / quotient bits}.
  logic [2*WIDTH-1:0] accQ;
  logic [WIDTH-1:0]   operandQ;  // multiplicand or divisor magnitude
  logic               isDivQ;
  logic               negLoQ;    // negate product, or quotient
  logic               negHiQ;    // negate remainder

  // Operand conditioning at launch
  logic             aNeg, bNeg, launch, isDivOp;
  logic [WIDTH-1:0] absA, absB;

  assign aNeg    = op[0] & srcA[WIDTH-1];
  assign bNeg    = op[0] & srcB[WIDTH-1];
  assign absA    = aNeg ? -srcA : srcA;
  assign absB    = bNeg ? -srcB : srcB;
  assign isDivOp = op[1];
  assign launch  = (stateQ == StIdle) && start && !op[2];

  // One shift-add multiply step
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;

  assign mulSum  = {1'b0, accQ[2*WIDTH-1:WIDTH]} + (accQ[0] ? {1'b0, operandQ} : '0);
  assign mulNext = {mulSum, accQ[WIDTH-1:1]};

  // One restoring divide step; the remainder always stays below the divisor so it fits WIDTH
  logic [WIDTH:0]     divShift;
  logic               divGe;
  logic [WIDTH-1:0]   divRem;
  logic [2*WIDTH-1:0] divNext;

  assign divShift = {accQ[2*WIDTH-1:WIDTH], accQ[WIDTH-1]};
  assign divGe    = divShift >= {1'b0, operandQ};
  assign divRem   = divGe ? WIDTH'(divShift - {1'b0, operandQ}) : divShift[WIDTH-1:0];
  assign divNext  = {divRem, accQ[WIDTH-2:0], divGe};

  // Sign fix-up applied while in SIGN
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix, remFix;

  assign prodFix = negLoQ ? -accQ : accQ;
  assign quoFix  = negLoQ ? -accQ[WIDTH-1:0] : accQ[WIDTH-1:0];
  assign remFix  = negHiQ ? -accQ[2*WIDTH-1:WIDTH] : accQ[2*WIDTH-1:WIDTH];

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:  if (start && !op[2]) stateD = StCalc;
      StCalc:  if (cntQ == '0) stateD = StSign;
      StSign:  stateD = StDone;
      StDone:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cntQ     <= '0;
      accQ     <= '0;
      operandQ <= '0;
      isDivQ   <= 1'b0;
      negLoQ   <= 1'b0;
      negHiQ   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      if (launch) begin
        cntQ     <= CntW'(WIDTH - 1);
        accQ     <= {{WIDTH{1'b0}}, (isDivOp ? absA : absB)};
        operandQ <= isDivOp ? absB : absA;
        isDivQ   <= isDivOp;
        // Divide by zero keeps the all-ones quotient regardless of signs
        negLoQ   <= (aNeg ^ bNeg) & !(isDivOp && (srcB == '0));
        negHiQ   <= aNeg;
      end
      if ((stateQ == StIdle) && start && (op == 3'b100)) hi <= srcA;
      if ((stateQ == StIdle) && start && (op == 3'b101)) lo <= srcA;
      if (stateQ == StCalc) begin
        accQ <= isDivQ ? divNext : mulNext;
        cntQ <= cntQ - 1'b1;
      end
      if (stateQ == StSign) begin
        if (isDivQ) begin
          hi <= remFix;
          lo <= quoFix;
        end else begin
          hi <= prodFix[2*WIDTH-1:WIDTH];
          lo <= prodFix[WIDTH-1:0];
        end
      end
    end
  end

  assign busy = (stateQ != StIdle);
  assign done = (stateQ == StDone);

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the driver pushes reference results into a queue, the
// monitor pops and compares whenever done pulses.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] srcA = 32'd0;
  logic [31:0] srcB = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .srcA (srcA),
    .srcB (srcB),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          doneCyc;
    string       name;
  } expT;

  expT expQ[$];
  expT monE;

  logic [31:0] modelHi = 32'd0;
  logic [31:0] modelLo = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic, returns {hi, lo}
  function automatic logic [63:0] refModel(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, q, rm;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 64'd0;
    case (o)
      3'd0: r = {32'd0, a} * {32'd0, b};
      3'd1: r = 64'(sa * sb);
      3'd2: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 32'd0) begin
          r = {a, 32'hFFFF_FFFF};
        end else begin
          q  = sa / sb;
          rm = sa % sb;
          r  = {rm[31:0], q[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (done) begin
      if (expQ.size() == 0) begin
        nTests++;
        nFail++;
        $display("FAIL unexpected done: got hi=%h lo=%h, required no done pulse", hi, lo);
      end else begin
        monE = expQ.pop_front();
        check($sformatf("%s hi/lo", monE.name), {hi, lo}, {monE.hi, monE.lo});
        check($sformatf("%s done cycle", monE.name), 64'(cyc), 64'(monE.doneCyc));
      end
    end
  end

  task automatic doOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input int injectAt, input int resetAt, input string name);
    logic [63:0] r;
    int c;
    int busyCnt;
    expT e;
    @(negedge clk);
    op    = o;
    srcA  = a;
    srcB  = b;
    start = 1'b1;
    c     = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (!o[2]) begin
      r         = refModel(o, a, b);
      e.hi      = r[63:32];
      e.lo      = r[31:0];
      e.doneCyc = c + 34;
      e.name    = name;
      expQ.push_back(e);
      modelHi = r[63:32];
      modelLo = r[31:0];
    end else if (o == 3'd4) begin
      modelHi = a;
    end else if (o == 3'd5) begin
      modelLo = a;
    end
    if (o[2]) begin
      @(negedge clk);
      check($sformatf("%s hi", name), 64'(hi), 64'(modelHi));
      check($sformatf("%s lo", name), 64'(lo), 64'(modelLo));
      check($sformatf("%s busy/done", name), {62'd0, busy, done}, 64'd0);
      return;
    end
    busyCnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      srcA = $urandom;  // must not disturb the op in flight
      srcB = $urandom;
      if (!busy) break;
      busyCnt++;
      if (busyCnt == injectAt) begin
        start = 1'b1;
        op    = 3'($urandom_range(0, 5));
      end else begin
        start = 1'b0;
      end
      rst_n = (busyCnt == resetAt) ? 1'b0 : 1'b1;
    end
    rst_n = 1'b1;
    start = 1'b0;
    if (resetAt > 0) begin
      expQ.delete();
      modelHi = 32'd0;
      modelLo = 32'd0;
      check($sformatf("%s hi/lo cleared", name), {hi, lo}, 64'd0);
      check($sformatf("%s busy cleared", name), {63'd0, busy}, 64'd0);
    end else begin
      check($sformatf("%s busy cycles", name), 64'(busyCnt), 64'd34);
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0] o;
    int r;
    int inj;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset state", {busy, done, hi, lo}, 66'd0);
    rst_n = 1'b1;

    doOp(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu max");
    doOp(3'd1, 32'hFFFF_FFFD, 32'h0000_0007, 0, 0, "mult -3*7");
    doOp(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, "div -7/2");
    doOp(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div overflow");
    doOp(3'd2, 32'h0000_0005, 32'h0000_0000, 0, 0, "divu by zero");
    doOp(3'd2, 32'h0000_0064, 32'h0000_0007, 0, 0, "divu 100/7");
    doOp(3'd4, 32'h0000_1234, 32'hDEAD_BEEF, 0, 0, "mthi");
    doOp(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5, 0, "multu start while busy");
    doOp(3'd0, 32'h0BAD_F00D, 32'h1357_9BDF, 0, 10, "reset mid calc");
    doOp(3'd0, 32'h0000_0003, 32'h0000_0004, 0, 0, "multu 3*4");
    doOp(3'd3, 32'h8000_0000, 32'h0000_0000, 0, 0, "div neg by zero");
    doOp(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 0, "mult min*min");
    doOp(3'd6, 32'hCAFE_0001, 32'h0, 0, 0, "noop 110");
    doOp(3'd5, 32'h5A5A_A5A5, 32'h0, 0, 0, "mtlo");

    for (int k = 0; k < 40; k++) begin
      r   = $urandom_range(0, 11);
      o   = (r < 8) ? 3'(r % 4) : 3'(r - 4);
      inj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
      doOp(o, pickOperand(), pickOperand(), inj, 0, $sformatf("rand%0d op%0d", k, o));
    end

    @(negedge clk);
    check("results drained", 64'(expQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
